// File: rtl/lvds_rx_aligner.sv
// rtl/lvds_rx_aligner.sv - LVDS deserializer word-boundary aligner (bitslip hunt + lock)
module lvds_rx_aligner #(
    parameter logic [7:0] TRAIN_PATTERN = 8'h0F,
    parameter int         LOCK_COUNT    = 16,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       realign,
    input  logic [7:0] rx_data,
    output logic       rx_data_align,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       aligned,
    output logic       align_err,
    output logic [3:0] slip_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        SETTLE,
        LOCKED,
        FAIL
    } state_t;

    localparam logic [7:0] LOCK_CNT_L  = 8'(LOCK_COUNT);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MAX_SLIPS_L = 4'(MAX_SLIPS);

    state_t     state, state_nxt;
    logic       run_q;
    logic [7:0] match_cnt, match_nxt, match_inc;
    logic [3:0] settle_cnt, settle_nxt;
    logic       slip_phase, slip_phase_nxt;
    logic [3:0] slip_nxt;
    logic [7:0] data_out_nxt;
    logic       align_nxt, valid_nxt, aligned_nxt, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            state         <= IDLE;
            match_cnt     <= 8'h00;
            settle_cnt    <= 4'h0;
            slip_phase    <= 1'b0;
            rx_data_align <= 1'b0;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            aligned       <= 1'b0;
            align_err     <= 1'b0;
            slip_cnt      <= 4'h0;
        end else begin
            run_q         <= 1'b1;
            state         <= state_nxt;
            match_cnt     <= match_nxt;
            settle_cnt    <= settle_nxt;
            slip_phase    <= slip_phase_nxt;
            rx_data_align <= align_nxt;
            data_out      <= data_out_nxt;
            data_valid    <= valid_nxt;
            aligned       <= aligned_nxt;
            align_err     <= err_nxt;
            slip_cnt      <= slip_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        match_nxt      = match_cnt;
        match_inc      = match_cnt + 8'd1;
        settle_nxt     = settle_cnt;
        slip_phase_nxt = 1'b0;
        slip_nxt       = slip_cnt;

        // run_q holds the FSM in IDLE for the first edge after reset release
        if (!run_q || !en) begin
            state_nxt = IDLE;
        end else if (realign && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = CHECK;
                    match_nxt = 8'h00;
                end
                CHECK: begin
                    if (rx_data == TRAIN_PATTERN) begin
                        if (match_inc >= LOCK_CNT_L) begin
                            match_nxt = LOCK_CNT_L;
                            state_nxt = LOCKED;
                        end else begin
                            match_nxt = match_inc;
                        end
                    end else begin
                        match_nxt = 8'h00;
                        if (slip_cnt < MAX_SLIPS_L) begin
                            state_nxt = SLIP;
                            slip_nxt  = slip_cnt + 4'd1;
                        end else begin
                            state_nxt = FAIL;
                        end
                    end
                end
                SLIP: begin
                    if (!slip_phase) begin
                        slip_phase_nxt = 1'b1;
                    end else begin
                        state_nxt  = SETTLE;
                        settle_nxt = 4'h0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt = CHECK;
                        match_nxt = 8'h00;
                    end else begin
                        settle_nxt = settle_cnt + 4'd1;
                    end
                end
                LOCKED: state_nxt = LOCKED;
                FAIL:   state_nxt = FAIL;
                default: state_nxt = IDLE;
            endcase
        end

        if (state_nxt == IDLE) begin
            slip_nxt  = 4'h0;
            match_nxt = 8'h00;
        end

        align_nxt   = (state_nxt == SLIP);
        aligned_nxt = (state_nxt == LOCKED);
        err_nxt     = (state_nxt == FAIL);
        // payload is only captured while staying locked, so data_out freezes otherwise
        valid_nxt    = (state == LOCKED) && (state_nxt == LOCKED);
        data_out_nxt = valid_nxt ? rx_data : data_out;
    end

endmodule
